// File: rtl/fir_decim_buffer.sv
// Post-FIR decimator: drops the start-up samples, keeps one strobe in every DECIM,
// and queues kept samples in a first-word-fall-through FIFO with a valid/ready drain.
module fir_decim_buffer #(
    parameter int DATA_WIDTH = 9,
    parameter int DECIM      = 2,
    parameter int PHASE      = 0,
    parameter int SKIP       = 5,
    parameter int DEPTH      = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [DATA_WIDTH-1:0]    data_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    input  logic                     clr_ovf
);

    localparam int AW  = $clog2(DEPTH);
    localparam int LW  = AW + 1;
    localparam int SKW = (SKIP > 0) ? $clog2(SKIP + 1) : 1;
    localparam int PW  = (DECIM > 1) ? $clog2(DECIM) : 1;

    localparam logic [SKW-1:0] SKIP_V     = SKW'(SKIP);
    localparam logic [PW-1:0]  PHASE_V    = PW'(PHASE);
    localparam logic [PW-1:0]  PHASE_LAST = PW'(DECIM - 1);
    localparam logic [LW-1:0]  FULL_V     = LW'(DEPTH);

    logic [SKW-1:0]        skip_cnt_q, skip_cnt_d;
    logic [PW-1:0]         phase_q, phase_d;
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         level_q, level_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  overflow_q, overflow_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic skip_done;
    logic keep;
    logic pop;
    logic push;
    logic drop;

    always_comb begin
        skip_done = (skip_cnt_q >= SKIP_V);
        keep      = en && skip_done && (phase_q == PHASE_V);
        pop       = out_valid_q && out_ready;
        push      = keep && ((level_q != FULL_V) || pop);
        drop      = keep && !push;

        skip_cnt_d = skip_cnt_q;
        if (en && !skip_done) begin
            skip_cnt_d = skip_cnt_q + SKW'(1);
        end

        phase_d = phase_q;
        if (en && skip_done) begin
            phase_d = (phase_q == PHASE_LAST) ? '0 : phase_q + PW'(1);
        end

        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = level_q + LW'(push) - LW'(pop);

        // The new head is the incoming sample only when it lands exactly at the next read slot.
        out_valid_d = (level_d != '0);
        out_data_d  = '0;
        if (out_valid_d) begin
            out_data_d = (push && (rd_ptr_d == wr_ptr_q)) ? data_in : mem_q[rd_ptr_d];
        end

        overflow_d = drop || (overflow_q && !clr_ovf);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skip_cnt_q  <= '0;
            phase_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            overflow_q  <= 1'b0;
        end else begin
            skip_cnt_q  <= skip_cnt_d;
            phase_q     <= phase_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            overflow_q  <= overflow_d;
        end
    end

    // Storage needs no reset: entries are only read once level says they were written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign level     = level_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_fir_decim_buffer.sv
// Directed bench for fir_decim_buffer: four parameterisations share one stimulus bus,
// and each scenario task checks only the instance configured for it.
module tb_fir_decim_buffer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic [8:0] data_in = '0;
    logic       out_ready = 1'b0;
    logic       clr_ovf = 1'b0;

    logic       valid_a, valid_b, valid_c, valid_d;
    logic [8:0] data_a, data_b, data_c, data_d;
    logic [2:0] level_a, level_b, level_c, level_d;
    logic       ovf_a, ovf_b, ovf_c, ovf_d;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fir_decim_buffer #(.DATA_WIDTH(9), .DECIM(2), .PHASE(0), .SKIP(5), .DEPTH(4)) dut_a (
        .clk(clk), .rst(rst), .en(en), .data_in(data_in), .out_valid(valid_a),
        .out_ready(out_ready), .out_data(data_a), .level(level_a), .overflow(ovf_a),
        .clr_ovf(clr_ovf));

    fir_decim_buffer #(.DATA_WIDTH(9), .DECIM(3), .PHASE(2), .SKIP(0), .DEPTH(4)) dut_b (
        .clk(clk), .rst(rst), .en(en), .data_in(data_in), .out_valid(valid_b),
        .out_ready(out_ready), .out_data(data_b), .level(level_b), .overflow(ovf_b),
        .clr_ovf(clr_ovf));

    fir_decim_buffer #(.DATA_WIDTH(9), .DECIM(1), .PHASE(0), .SKIP(0), .DEPTH(4)) dut_c (
        .clk(clk), .rst(rst), .en(en), .data_in(data_in), .out_valid(valid_c),
        .out_ready(out_ready), .out_data(data_c), .level(level_c), .overflow(ovf_c),
        .clr_ovf(clr_ovf));

    fir_decim_buffer #(.DATA_WIDTH(9), .DECIM(2), .PHASE(0), .SKIP(0), .DEPTH(4)) dut_d (
        .clk(clk), .rst(rst), .en(en), .data_in(data_in), .out_valid(valid_d),
        .out_ready(out_ready), .out_data(data_d), .level(level_d), .overflow(ovf_d),
        .clr_ovf(clr_ovf));

    // One clock: inputs change on the falling edge, outputs are looked at 1ns after the rising edge.
    task automatic step(input logic e, input logic [8:0] d, input logic r, input logic c);
        @(negedge clk);
        en        = e;
        data_in   = d;
        out_ready = r;
        clr_ovf   = c;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; en = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0; data_in = '0;
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        logic [8:0] exp_d;
        do_reset();
        checks++;
        if ({valid_a, data_a, level_a, ovf_a} !== 14'd0) begin
            errors++;
            $display("[TB] FAIL reset_init: got v=%0d d=%0h l=%0d o=%0d, need all 0",
                     valid_a, data_a, level_a, ovf_a);
        end
        for (int i = 1; i <= 10; i++) step(1'b1, 9'(i), 1'b0, 1'b0);
        checks++;
        if (level_a !== 3'd3 || data_a !== 9'd6) begin
            errors++;
            $display("[TB] FAIL reset_prefill: got level=%0d data=%0d, need level=3 data=6",
                     level_a, data_a);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({valid_a, data_a, level_a, ovf_a} !== 14'd0) begin
            errors++;
            $display("[TB] FAIL reset_async: got v=%0d d=%0h l=%0d o=%0d, need all 0",
                     valid_a, data_a, level_a, ovf_a);
        end
        @(negedge clk);
        rst = 1'b0; en = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            step(1'b1, 9'(i), 1'b1, 1'b0);
            exp_d = (i == 6 || i == 8) ? 9'(i) : 9'd0;
            checks++;
            if (valid_a !== (exp_d != 0) || data_a !== exp_d) begin
                errors++;
                $display("[TB] FAIL skip_strobe%0d: got v=%0d d=%0d, need v=%0d d=%0d",
                         i, valid_a, data_a, (exp_d != 0), exp_d);
            end
        end
    endtask

    task automatic test_decimation();
        logic [8:0] exp_d;
        do_reset();
        for (int i = 0; i <= 11; i++) begin
            step(1'b1, 9'(i), 1'b1, 1'b0);
            exp_d = (i % 3 == 2) ? 9'(i) : 9'd0;
            checks++;
            if (valid_b !== (i % 3 == 2) || data_b !== exp_d) begin
                errors++;
                $display("[TB] FAIL decim_strobe%0d: got v=%0d d=%0d, need v=%0d d=%0d",
                         i, valid_b, data_b, (i % 3 == 2), exp_d);
            end
        end
    endtask

    task automatic test_overflow();
        logic [8:0] exp_q [4] = '{9'd10, 9'd20, 9'd30, 9'd40};
        do_reset();
        for (int i = 1; i <= 5; i++) step(1'b1, 9'(i * 10), 1'b0, 1'b0);
        checks++;
        if (level_c !== 3'd4 || ovf_c !== 1'b1 || data_c !== 9'd10) begin
            errors++;
            $display("[TB] FAIL ovf_full: got level=%0d ovf=%0d data=%0d, need 4 1 10",
                     level_c, ovf_c, data_c);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (valid_c !== 1'b1 || data_c !== exp_q[i]) begin
                errors++;
                $display("[TB] FAIL ovf_drain%0d: got v=%0d d=%0d, need v=1 d=%0d",
                         i, valid_c, data_c, exp_q[i]);
            end
            step(1'b0, 9'd0, 1'b1, 1'b0);
        end
        checks++;
        if (valid_c !== 1'b0 || level_c !== 3'd0 || data_c !== 9'd0 || ovf_c !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ovf_empty: got v=%0d l=%0d d=%0d o=%0d, need 0 0 0 1",
                     valid_c, level_c, data_c, ovf_c);
        end
    endtask

    task automatic test_full_pop();
        logic [8:0] exp_q [4] = '{9'd2, 9'd3, 9'd4, 9'd5};
        do_reset();
        for (int i = 1; i <= 4; i++) step(1'b1, 9'(i), 1'b0, 1'b0);
        checks++;
        if (level_c !== 3'd4 || data_c !== 9'd1) begin
            errors++;
            $display("[TB] FAIL fullpop_fill: got level=%0d data=%0d, need 4 1",
                     level_c, data_c);
        end
        step(1'b1, 9'd5, 1'b1, 1'b0);
        checks++;
        if (level_c !== 3'd4 || ovf_c !== 1'b0 || data_c !== 9'd2) begin
            errors++;
            $display("[TB] FAIL fullpop_same: got level=%0d ovf=%0d data=%0d, need 4 0 2",
                     level_c, ovf_c, data_c);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (valid_c !== 1'b1 || data_c !== exp_q[i]) begin
                errors++;
                $display("[TB] FAIL fullpop_drain%0d: got v=%0d d=%0d, need v=1 d=%0d",
                         i, valid_c, data_c, exp_q[i]);
            end
            step(1'b0, 9'd0, 1'b1, 1'b0);
        end
        checks++;
        if (level_c !== 3'd0 || valid_c !== 1'b0) begin
            errors++;
            $display("[TB] FAIL fullpop_empty: got level=%0d v=%0d, need 0 0", level_c, valid_c);
        end
    endtask

    task automatic test_sign_clear();
        logic [8:0] exp_q [3] = '{9'h100, 9'h0FF, 9'h1FF};
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, exp_q[i], 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (valid_c !== 1'b1 || data_c !== exp_q[i]) begin
                errors++;
                $display("[TB] FAIL sign%0d: got v=%0d d=%h, need v=1 d=%h",
                         i, valid_c, data_c, exp_q[i]);
            end
            step(1'b0, 9'd0, 1'b1, 1'b0);
        end
        for (int i = 1; i <= 5; i++) step(1'b1, 9'(i), 1'b0, 1'b0);
        checks++;
        if (ovf_c !== 1'b1) begin
            errors++;
            $display("[TB] FAIL clr_setup: got ovf=%0d, need 1", ovf_c);
        end
        step(1'b0, 9'd0, 1'b0, 1'b1);
        checks++;
        if (ovf_c !== 1'b0) begin
            errors++;
            $display("[TB] FAIL clr_plain: got ovf=%0d, need 0", ovf_c);
        end
        step(1'b1, 9'd77, 1'b0, 1'b1);
        checks++;
        if (ovf_c !== 1'b1 || level_c !== 3'd4 || data_c !== 9'd1) begin
            errors++;
            $display("[TB] FAIL clr_with_drop: got ovf=%0d level=%0d data=%0d, need 1 4 1",
                     ovf_c, level_c, data_c);
        end
    endtask

    task automatic test_intermittent();
        logic [8:0] sent [12];
        int n;
        int pops;
        n    = 0;
        pops = 0;
        for (int i = 0; i < 12; i++) sent[i] = 9'((i * 37 + 200) % 512);
        do_reset();
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            en        = (c % 3 == 0) && (n < 12);
            data_in   = en ? sent[n] : 9'd0;
            out_ready = (c % 2 == 1);
            clr_ovf   = 1'b0;
            if (valid_d && out_ready) begin
                checks++;
                if (pops >= 6 || data_d !== sent[2 * pops]) begin
                    errors++;
                    $display("[TB] FAIL intermittent_pop%0d: got d=%0d, need d=%0d",
                             pops, data_d, (pops < 6) ? sent[2 * pops] : 9'd0);
                end
                pops++;
            end
            if (en) n++;
        end
        @(negedge clk);
        en = 1'b0; out_ready = 1'b0;
        checks++;
        if (pops !== 6 || level_d !== 3'd0 || ovf_d !== 1'b0) begin
            errors++;
            $display("[TB] FAIL intermittent_count: got pops=%0d level=%0d ovf=%0d, need 6 0 0",
                     pops, level_d, ovf_d);
        end
    endtask

    initial begin
        test_reset();
        test_decimation();
        test_overflow();
        test_full_pop();
        test_sign_clear();
        test_intermittent();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
